// File: rtl/ysyx_22050710_sram_arbiter_pkg.sv
// rtl/ysyx_22050710_sram_arbiter_pkg.sv - shared widths, state and owner encodings for the SRAM arbiter
package ysyx_22050710_sram_arbiter_pkg;

    localparam int SRAM_ADDR_WD  = 32;
    localparam int SRAM_DATA_WD  = 64;
    localparam int SRAM_WMASK_WD = SRAM_DATA_WD / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_22050710_rr_arb2.sv
// rtl/ysyx_22050710_rr_arb2.sv - two-way round-robin pick between instruction and data requesters
module ysyx_22050710_rr_arb2
    import ysyx_22050710_sram_arbiter_pkg::*;
(
    input  logic   req_inst,
    input  logic   req_data,
    input  owner_e last_grant,
    output logic   gnt_inst,
    output logic   gnt_data
);

    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        if (req_inst && req_data) begin
            // On a tie the side that did not win last time goes first.
            if (last_grant == OWNER_INST) begin
                gnt_data = 1'b1;
            end else begin
                gnt_inst = 1'b1;
            end
        end else begin
            gnt_inst = req_inst;
            gnt_data = req_data;
        end
    end

endmodule

// File: rtl/ysyx_22050710_sram_arbiter.sv
// rtl/ysyx_22050710_sram_arbiter.sv - shares one memory port between IF reads and EX loads/stores
module ysyx_22050710_sram_arbiter
    import ysyx_22050710_sram_arbiter_pkg::*;
#(
    parameter int AW = SRAM_ADDR_WD,
    parameter int DW = SRAM_DATA_WD,
    parameter int MW = SRAM_WMASK_WD
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_inst_req,
    input  logic [AW-1:0] i_inst_addr,
    output logic          o_inst_ready,
    output logic          o_inst_rvalid,
    output logic [DW-1:0] o_inst_rdata,
    input  logic          i_data_req,
    input  logic          i_data_wen,
    input  logic [AW-1:0] i_data_addr,
    input  logic [MW-1:0] i_data_wmask,
    input  logic [DW-1:0] i_data_wdata,
    output logic          o_data_ready,
    output logic          o_data_rvalid,
    output logic [DW-1:0] o_data_rdata,
    output logic          o_mem_req,
    output logic          o_mem_wen,
    output logic [AW-1:0] o_mem_addr,
    output logic [MW-1:0] o_mem_wmask,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_ack,
    input  logic          i_mem_rvalid,
    input  logic [DW-1:0] i_mem_rdata
);

    arb_state_e    state;
    owner_e        owner;
    owner_e        last_grant;
    logic          lat_wen;
    logic [AW-1:0] lat_addr;
    logic [MW-1:0] lat_wmask;
    logic [DW-1:0] lat_wdata;

    logic grant_ok;
    logic gnt_inst;
    logic gnt_data;
    logic mem_done;

    // Nothing is granted while reset is held, so outputs stay quiet through reset.
    assign grant_ok = (state == ST_IDLE) && i_rst;

    ysyx_22050710_rr_arb2 u_rr_arb2 (
        .req_inst   (i_inst_req & grant_ok),
        .req_data   (i_data_req & grant_ok),
        .last_grant (last_grant),
        .gnt_inst   (gnt_inst),
        .gnt_data   (gnt_data)
    );

    assign mem_done = i_mem_rvalid &&
                      ((state == ST_WAIT) || ((state == ST_REQ) && i_mem_ack));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            owner      <= OWNER_INST;
            last_grant <= OWNER_INST;
            lat_wen    <= 1'b0;
            lat_addr   <= '0;
            lat_wmask  <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_inst || gnt_data) begin
                        state      <= ST_REQ;
                        owner      <= gnt_data ? OWNER_DATA : OWNER_INST;
                        last_grant <= gnt_data ? OWNER_DATA : OWNER_INST;
                        lat_wen    <= gnt_data & i_data_wen;
                        lat_addr   <= gnt_data ? i_data_addr  : i_inst_addr;
                        lat_wmask  <= gnt_data ? i_data_wmask : '0;
                        lat_wdata  <= gnt_data ? i_data_wdata : '0;
                    end
                end
                ST_REQ: begin
                    if (i_mem_ack) begin
                        state <= i_mem_rvalid ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_mem_rvalid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_inst_ready = gnt_inst;
    assign o_data_ready = gnt_data;

    // Memory side comes only from registered state, never from i_mem_*.
    assign o_mem_req   = (state == ST_REQ);
    assign o_mem_wen   = o_mem_req & lat_wen;
    assign o_mem_addr  = o_mem_req ? lat_addr  : '0;
    assign o_mem_wmask = o_mem_req ? lat_wmask : '0;
    assign o_mem_wdata = o_mem_req ? lat_wdata : '0;

    assign o_inst_rvalid = mem_done && (owner == OWNER_INST);
    assign o_data_rvalid = mem_done && (owner == OWNER_DATA);
    assign o_inst_rdata  = o_inst_rvalid ? i_mem_rdata : '0;
    assign o_data_rdata  = o_data_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// tb/tb_ysyx_22050710_sram_arbiter.sv - scoreboard bench for the SRAM arbiter
module tb_ysyx_22050710_sram_arbiter;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_inst_req;
    logic [31:0] i_inst_addr;
    logic        o_inst_ready, o_inst_rvalid;
    logic [63:0] o_inst_rdata;
    logic        i_data_req, i_data_wen;
    logic [31:0] i_data_addr;
    logic [7:0]  i_data_wmask;
    logic [63:0] i_data_wdata;
    logic        o_data_ready, o_data_rvalid;
    logic [63:0] o_data_rdata;
    logic        o_mem_req, o_mem_wen;
    logic [31:0] o_mem_addr;
    logic [7:0]  o_mem_wmask;
    logic [63:0] o_mem_wdata;
    logic        i_mem_ack, i_mem_rvalid;
    logic [63:0] i_mem_rdata;

    typedef struct {logic who; int cyc;} rdy_t;
    typedef struct {logic wen; logic [31:0] addr; logic [7:0] wmask; logic [63:0] wdata; int cyc;} mem_t;
    typedef struct {logic who; logic [63:0] rdata; int cyc;} rsp_t;

    rdy_t        rdy_q[$];
    mem_t        mem_q[$];
    rsp_t        rsp_q[$];
    logic [63:0] rdata_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int ack_dly = 0;
    int rsp_dly = 1;
    int mphase = 0;
    int wcnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_22050710_sram_arbiter dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr),
        .o_inst_ready(o_inst_ready), .o_inst_rvalid(o_inst_rvalid), .o_inst_rdata(o_inst_rdata),
        .i_data_req(i_data_req), .i_data_wen(i_data_wen), .i_data_addr(i_data_addr),
        .i_data_wmask(i_data_wmask), .i_data_wdata(i_data_wdata),
        .o_data_ready(o_data_ready), .o_data_rvalid(o_data_rvalid), .o_data_rdata(o_data_rdata),
        .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
        .o_mem_wmask(o_mem_wmask), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ready(input logic who, input int c);
        rdy_t r;
        r.who = who; r.cyc = c;
        rdy_q.push_back(r);
    endtask

    task automatic exp_mem(input logic wen, input logic [31:0] addr, input logic [7:0] wmask,
                           input logic [63:0] wdata, input int c);
        mem_t m;
        m.wen = wen; m.addr = addr; m.wmask = wmask; m.wdata = wdata; m.cyc = c;
        mem_q.push_back(m);
    endtask

    task automatic exp_rsp(input logic who, input logic [63:0] rdata, input int c);
        rsp_t s;
        s.who = who; s.rdata = rdata; s.cyc = c;
        rsp_q.push_back(s);
        rdata_q.push_back(rdata);
    endtask

    task automatic drain();
        int n = 0;
        while ((rdy_q.size() != 0 || mem_q.size() != 0 || rsp_q.size() != 0 || mphase != 0) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_pending", {32'(rdy_q.size()), 32'(mem_q.size()), 32'(rsp_q.size())}, 128'd0);
        tick();
        tick();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_side"}, {o_inst_ready, o_inst_rvalid, o_inst_rdata, o_data_ready, o_data_rvalid},
            128'd0);
        chk({tag, "_mem_side"}, {o_data_rdata, o_mem_req, o_mem_wen, o_mem_addr, o_mem_wmask}, 128'd0);
        chk({tag, "_mem_wdata"}, {64'd0, o_mem_wdata}, 128'd0);
    endtask

    // Memory model: acks after ack_dly cycles of o_mem_req, answers rsp_dly cycles after the ack.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_mem_ack = 1'b0;
            i_mem_rvalid = 1'b0;
            i_mem_rdata = 64'd0;
            if (mphase == 0 && o_mem_req) begin
                mphase = 1;
                wcnt = 0;
            end
            if (mphase == 1) begin
                if (wcnt == ack_dly) begin
                    i_mem_ack = 1'b1;
                    if (rsp_dly == 0) begin
                        i_mem_rvalid = 1'b1;
                        i_mem_rdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : 64'd0;
                        mphase = 0;
                    end else begin
                        mphase = 2;
                        wcnt = 0;
                    end
                end else begin
                    wcnt++;
                end
            end else if (mphase == 2) begin
                wcnt++;
                if (wcnt == rsp_dly) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : 64'd0;
                    mphase = 0;
                end
            end
        end
    end

    // Monitor: every DUT event must match the head of its expectation queue.
    always @(negedge clk) begin
        rdy_t r;
        mem_t m;
        rsp_t s;
        if (o_inst_ready || o_data_ready) begin
            if (rdy_q.size() == 0) begin
                chk("ready_unexpected", {126'd0, o_inst_ready, o_data_ready}, 128'd0);
            end else begin
                r = rdy_q.pop_front();
                chk("ready_who", {126'd0, o_inst_ready, o_data_ready}, {126'd0, r.who ? 2'b01 : 2'b10});
                chk("ready_cycle", 128'(cyc), 128'(r.cyc));
            end
        end
        if (o_mem_req) begin
            if (mem_q.size() == 0) begin
                chk("mem_unexpected", {127'd0, o_mem_req}, 128'd0);
            end else begin
                m = mem_q[0];
                chk("mem_fields", {23'd0, o_mem_wen, o_mem_addr, o_mem_wmask, o_mem_wdata},
                    {23'd0, m.wen, m.addr, m.wmask, m.wdata});
                if (i_mem_ack) begin
                    chk("mem_ack_cycle", 128'(cyc), 128'(m.cyc));
                    void'(mem_q.pop_front());
                end
            end
        end else begin
            chk("mem_idle_zero", {23'd0, o_mem_wen, o_mem_addr, o_mem_wmask, o_mem_wdata}, 128'd0);
        end
        if (o_inst_rvalid || o_data_rvalid) begin
            if (rsp_q.size() == 0) begin
                chk("rvalid_unexpected", {126'd0, o_inst_rvalid, o_data_rvalid}, 128'd0);
            end else begin
                s = rsp_q.pop_front();
                chk("rvalid_who", {126'd0, o_inst_rvalid, o_data_rvalid}, {126'd0, s.who ? 2'b01 : 2'b10});
                chk("rdata", {o_inst_rdata, o_data_rdata}, s.who ? {64'd0, s.rdata} : {s.rdata, 64'd0});
                chk("rvalid_cycle", 128'(cyc), 128'(s.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    initial begin
        int c;
        i_rst = 1'b0;
        i_inst_req = 1'b0; i_inst_addr = 32'd0;
        i_data_req = 1'b0; i_data_wen = 1'b0; i_data_addr = 32'd0;
        i_data_wmask = 8'd0; i_data_wdata = 64'd0;
        i_mem_ack = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 64'd0;
        tick();
        tick();
        chk_quiet("reset");
        i_rst = 1'b1;

        // 1: simultaneous requests after reset, data wins, inst follows its rvalid
        tick();
        i_data_req = 1'b1; i_data_wen = 1'b0; i_data_addr = 32'h8000_1000;
        i_inst_req = 1'b1; i_inst_addr = 32'h8000_0004;
        c = cyc;
        exp_ready(1'b1, c);
        exp_mem(1'b0, 32'h8000_1000, 8'h00, 64'd0, c + 1);
        exp_rsp(1'b1, 64'h0123_4567_89ab_cdef, c + 2);
        exp_ready(1'b0, c + 3);
        exp_mem(1'b0, 32'h8000_0004, 8'h00, 64'd0, c + 4);
        exp_rsp(1'b0, 64'h0000_0000_0000_0013, c + 5);
        tick();
        i_data_req = 1'b0; i_data_addr = 32'hFFFF_FFF0;
        tick();
        tick();
        tick();
        i_inst_req = 1'b0; i_inst_addr = 32'h0000_1234;
        drain();

        // 3: store carries wen/mask/data; only the data side sees rvalid
        tick();
        i_data_req = 1'b1; i_data_wen = 1'b1; i_data_addr = 32'h8000_0010;
        i_data_wmask = 8'hF0; i_data_wdata = 64'h1122_3344_5566_7788;
        c = cyc;
        exp_ready(1'b1, c);
        exp_mem(1'b1, 32'h8000_0010, 8'hF0, 64'h1122_3344_5566_7788, c + 1);
        exp_rsp(1'b1, 64'h0000_0000_0000_5a5a, c + 2);
        tick();
        i_data_req = 1'b0; i_data_wen = 1'b0; i_data_wmask = 8'd0; i_data_wdata = 64'd0;
        drain();

        // 2: both held, grants alternate inst,data,... every 3 cycles
        tick();
        i_inst_req = 1'b1; i_inst_addr = 32'h8000_0100;
        i_data_req = 1'b1; i_data_wen = 1'b0; i_data_addr = 32'h8000_2000;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_ready(k[0], c + 3 * k);
            exp_mem(1'b0, k[0] ? 32'h8000_2000 : 32'h8000_0100, 8'h00, 64'd0, c + 3 * k + 1);
            exp_rsp(k[0], 64'h1000 + 64'(k), c + 3 * k + 2);
        end
        repeat (10) tick();
        i_inst_req = 1'b0;
        i_data_req = 1'b0;
        drain();

        // 4: slow ack and response, requester drops and changes its inputs meanwhile
        ack_dly = 4;
        rsp_dly = 3;
        tick();
        i_inst_req = 1'b1; i_inst_addr = 32'h8000_0000;
        c = cyc;
        exp_ready(1'b0, c);
        exp_mem(1'b0, 32'h8000_0000, 8'h00, 64'd0, c + 5);
        exp_rsp(1'b0, 64'h0000_0000_dead_beef, c + 8);
        tick();
        i_inst_req = 1'b0; i_inst_addr = 32'h8000_0040; i_data_addr = 32'h0BAD_0000;
        drain();

        // 5: ack and rvalid together, next grant one cycle later
        ack_dly = 0;
        rsp_dly = 0;
        tick();
        i_data_req = 1'b1; i_data_wen = 1'b0; i_data_addr = 32'h8000_3000;
        i_inst_req = 1'b1; i_inst_addr = 32'h8000_0200;
        c = cyc;
        exp_ready(1'b1, c);
        exp_mem(1'b0, 32'h8000_3000, 8'h00, 64'd0, c + 1);
        exp_rsp(1'b1, 64'h55, c + 1);
        exp_ready(1'b0, c + 2);
        exp_mem(1'b0, 32'h8000_0200, 8'h00, 64'd0, c + 3);
        exp_rsp(1'b0, 64'h66, c + 3);
        tick();
        i_data_req = 1'b0;
        tick();
        tick();
        i_inst_req = 1'b0;
        drain();

        // 6: reset in WAIT drops the late response; data wins the next tie
        rsp_dly = 3;
        tick();
        i_inst_req = 1'b1; i_inst_addr = 32'h8000_0300;
        c = cyc;
        exp_ready(1'b0, c);
        exp_mem(1'b0, 32'h8000_0300, 8'h00, 64'd0, c + 1);
        rdata_q.push_back(64'h0000_0000_0000_0bad);
        tick();
        i_inst_req = 1'b0;
        tick();
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        chk_quiet("after_wait_reset");
        tick();
        tick();
        rsp_dly = 1;
        i_data_req = 1'b1; i_data_wen = 1'b0; i_data_addr = 32'h8000_4000;
        i_inst_req = 1'b1; i_inst_addr = 32'h8000_0400;
        c = cyc;
        exp_ready(1'b1, c);
        exp_mem(1'b0, 32'h8000_4000, 8'h00, 64'd0, c + 1);
        exp_rsp(1'b1, 64'h0000_0000_0000_cafe, c + 2);
        tick();
        i_data_req = 1'b0;
        i_inst_req = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
